alu_arbiter: RTL and testbench

- Shares the single registered ALU (ALUOp/Reg1Val/ALUInput2 in, ALUOut/zero out, one-cycle latency) between two requesters.
- Port 0 is the main datapath; port 1 is a secondary unit, e.g. branch-target or address-calculation logic.
- Grants one operation per cycle, drives the ALU inputs combinationally, and routes the result and zero flag back to the owning port one cycle later.
- Supports round-robin arbitration, or fixed priority with starvation protection.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters, one op per cycle,
// with round-robin (MODE 0) or fixed priority plus starvation guard (MODE 1). Rev 1.0
`default_nettype none

module alu_arbiter #(
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [3:0]  op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        gnt0,
  output logic        rsp_valid0,
  input  logic        req1,
  input  logic [3:0]  op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt1,
  output logic        rsp_valid1,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] OP_IDLE = 4'b1111;

  logic       rr_ptr;
  logic [3:0] starve_cnt;
  logic       iss_valid;
  logic       iss_id;
  logic       contend;

  assign contend = req0 & req1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (contend) begin
        if (MODE == 0) begin
          gnt1 = rr_ptr;
        end else begin
          gnt1 = (starve_cnt == LIMIT);
        end
        gnt0 = ~gnt1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // The idle opcode makes the ALU produce 0, keeping its output quiet between ops.
  always_comb begin
    alu_op = OP_IDLE;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (gnt0) begin
      alu_op = op0;
      alu_a  = a0;
      alu_b  = b0;
    end else if (gnt1) begin
      alu_op = op1;
      alu_a  = a1;
      alu_b  = b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      starve_cnt <= 4'd0;
      iss_valid  <= 1'b0;
      iss_id     <= 1'b0;
    end else begin
      iss_valid <= gnt0 | gnt1;
      iss_id    <= gnt1;
      if (MODE == 0) begin
        if (gnt0 | gnt1) begin
          rr_ptr <= gnt0;
        end
      end else begin
        if (gnt1) begin
          starve_cnt <= 4'd0;
        end else if (contend && gnt0 && (starve_cnt != LIMIT)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

  // The ALU result lands exactly one cycle after issue, so it is forwarded unregistered.
  assign rsp_valid0 = ~rst & iss_valid & ~iss_id;
  assign rsp_valid1 = ~rst & iss_valid & iss_id;
  assign rsp_data   = alu_out;
  assign rsp_zero   = alu_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives a round-robin and a fixed-priority instance with the same stimulus
// and compares both against a cycle-level behavioural model. Rev 1.0
`default_nettype none

module tb_alu_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        gnt0_w [2];
  logic        gnt1_w [2];
  logic        rv0_w [2];
  logic        rv1_w [2];
  logic        rz_w [2];
  logic        alu_zero_w [2];
  logic [31:0] rd_w [2];
  logic [31:0] alu_a_w [2];
  logic [31:0] alu_b_w [2];
  logic [31:0] alu_out_w [2];
  logic [3:0]  alu_op_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  int          fav [2];
  int          wins [2];
  bit          pv [2];
  bit          pid [2];
  logic [31:0] pres [2];

  alu_arbiter #(.MODE(0), .STARVE_LIMIT(LIMIT)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0_w[0]), .rsp_valid0(rv0_w[0]),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1_w[0]), .rsp_valid1(rv1_w[0]),
    .rsp_data(rd_w[0]), .rsp_zero(rz_w[0]),
    .alu_op(alu_op_w[0]), .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]),
    .alu_out(alu_out_w[0]), .alu_zero(alu_zero_w[0])
  );

  alu_arbiter #(.MODE(1), .STARVE_LIMIT(LIMIT)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0_w[1]), .rsp_valid0(rv0_w[1]),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1_w[1]), .rsp_valid1(rv1_w[1]),
    .rsp_data(rd_w[1]), .rsp_zero(rz_w[1]),
    .alu_op(alu_op_w[1]), .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]),
    .alu_out(alu_out_w[1]), .alu_zero(alu_zero_w[1])
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0011: return x - y;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU, one per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      alu_out_w[k]  <= alu_ref(alu_op_w[k], alu_a_w[k], alu_b_w[k]);
      alu_zero_w[k] <= (alu_ref(alu_op_w[k], alu_a_w[k], alu_b_w[k]) == 32'd0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rs,
                      input bit q0, input logic [3:0] p0, input logic [31:0] x0, input logic [31:0] y0,
                      input bit q1, input logic [3:0] p1, input logic [31:0] x1, input logic [31:0] y1);
    bit          e0, e1;
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    @(posedge clk);
    #1;
    rst = rs; req0 = q0; op0 = p0; a0 = x0; b0 = y0;
    req1 = q1; op1 = p1; a1 = x1; b1 = y1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rs) begin
        if (q0 && q1) begin
          if (m == 0) e1 = (fav[m] == 1);
          else        e1 = (wins[m] >= LIMIT);
          e0 = !e1;
        end else begin
          e0 = q0;
          e1 = q1;
        end
      end
      eop = e0 ? p0 : (e1 ? p1 : 4'hF);
      ea  = e0 ? x0 : (e1 ? x1 : 32'd0);
      eb  = e0 ? y0 : (e1 ? y1 : 32'd0);
      check($sformatf("m%0d gnt0", m), 32'(gnt0_w[m]), 32'(e0));
      check($sformatf("m%0d gnt1", m), 32'(gnt1_w[m]), 32'(e1));
      check($sformatf("m%0d alu_op", m), 32'(alu_op_w[m]), 32'(eop));
      check($sformatf("m%0d alu_a", m), alu_a_w[m], ea);
      check($sformatf("m%0d alu_b", m), alu_b_w[m], eb);
      check($sformatf("m%0d rsp_valid0", m), 32'(rv0_w[m]), 32'(!rs && pv[m] && !pid[m]));
      check($sformatf("m%0d rsp_valid1", m), 32'(rv1_w[m]), 32'(!rs && pv[m] && pid[m]));
      if (!rs && pv[m]) begin
        check($sformatf("m%0d rsp_data", m), rd_w[m], pres[m]);
        check($sformatf("m%0d rsp_zero", m), 32'(rz_w[m]), 32'(pres[m] == 32'd0));
      end
      if (rs) begin
        fav[m]  = 0;
        wins[m] = 0;
        pv[m]   = 1'b0;
        pid[m]  = 1'b0;
      end else begin
        pv[m]   = e0 | e1;
        pid[m]  = e1;
        pres[m] = alu_ref(eop, ea, eb);
        if (e0) fav[m] = 1;
        else if (e1) fav[m] = 0;
        if (e1) wins[m] = 0;
        else if (q0 && q1 && wins[m] < LIMIT) wins[m]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = 4'h0; op1 = 4'h0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int m = 0; m < 2; m++) begin
      fav[m] = 0; wins[m] = 0; pv[m] = 0; pid[m] = 0; pres[m] = 0;
    end

    step(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    step(1, 1, 4'h2, 3, 4, 1, 4'h1, 5, 6);
    idle(1);

    // Single port 0 ADD
    step(0, 1, 4'b0010, 5, 7, 0, 4'h0, 0, 0);
    idle(2);

    // Contention: SUB 9-9 against OR F0|0F; 10 cycles covers the starvation pattern
    for (int i = 0; i < 10; i++) step(0, 1, 4'b0011, 9, 9, 1, 4'b0001, 32'hF0, 32'h0F);
    idle(1);

    // Back-to-back port 1 ANDs with changing operands
    step(0, 0, 4'h0, 0, 0, 1, 4'b0000, 32'hFFFF0000, 32'h00FF00FF);
    step(0, 0, 4'h0, 0, 0, 1, 4'b0000, 1, 1);
    step(0, 0, 4'h0, 0, 0, 1, 4'b0000, 2, 1);
    idle(1);

    // Reset mid-op, then contention right after reset
    step(0, 1, 4'b0010, 1, 1, 0, 4'h0, 0, 0);
    step(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 1, 4'b0010, 2, 3, 1, 4'b0010, 4, 5);
    step(0, 1, 4'b0010, 2, 3, 1, 4'b0010, 4, 5);
    idle(1);

    // Withdrawn port 1 request during a port 0 win, then contention
    step(0, 0, 4'h0, 0, 0, 1, 4'b0001, 8, 1);
    step(0, 1, 4'b0010, 10, 20, 1, 4'b0001, 7, 7);
    step(0, 1, 4'b0010, 11, 20, 0, 4'b0001, 7, 7);
    idle(1);
    step(0, 1, 4'b0011, 3, 3, 1, 4'b0001, 1, 2);
    step(0, 1, 4'b0011, 3, 3, 1, 4'b0001, 1, 2);
    idle(1);

    // Randomized traffic with occasional reset and illegal opcodes
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      step($urandom_range(0, 60) == 0,
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)), ra0, rb0,
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)), ra1, rb1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
